mem_request_agent: RTL and testbench

Client-side NOC agent that turns single-line load/store requests from a core or cache into `memory_write_request` / `memory_read_request` packets for the memory interface. It consumes the matching `memory_read_reply` packets and returns line data to the client. It sits on one NIU port, directly upstream of the memory interface. Exactly one request is outstanding at a time.

---
 rtl/mem_request_agent.sv | 209 ++++++++++++++++++++
 tb/tb_mem_request_agent.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_request_agent.sv
// rtl/mem_request_agent.sv - single-outstanding load/store agent that packs client line requests into NOC memory packets.
`ifndef MEMORY_INTERFACE_NOC_ADDR
`define MEMORY_INTERFACE_NOC_ADDR 8'hF0
`endif

package mem_request_agent_pkg;
   typedef enum logic [7:0] {
      memory_write_request = 8'h01,
      memory_read_request  = 8'h02,
      memory_read_reply    = 8'h03
   } mem_pt_e;

   typedef struct packed {
      logic [7:0] len;
      logic [7:0] src_addr;
      logic [3:0] src_port;
      logic [7:0] dst_addr;
      logic [3:0] dst_port;
   } noc_packet_header;

   // Packet type sits in the low byte so receivers can decode dat[7:0] before knowing the layout.
   typedef struct packed {
      logic [127:0] dat;
      logic [31:0]  addr;
      mem_pt_e      pt;
   } mem_wr_rq;

   typedef struct packed {
      logic [31:0] addr;
      mem_pt_e     pt;
   } mem_rd_rq;

   typedef struct packed {
      logic [127:0] dat;
      logic [31:0]  addr;
      mem_pt_e      pt;
   } mem_rd_rp;

   localparam int NOC_PAYLOAD_W = $bits(mem_wr_rq);

   typedef struct packed {
      noc_packet_header           hdr;
      logic [NOC_PAYLOAD_W-1:0]   dat;
   } noc_packet;
endpackage

module mem_request_agent
   import mem_request_agent_pkg::*;
#(
   parameter logic [7:0] SRC_ADDR = 8'd0,
   parameter logic [3:0] SRC_PORT = 4'd0,
   parameter logic [7:0] DST_ADDR = `MEMORY_INTERFACE_NOC_ADDR,
   parameter logic [3:0] DST_PORT = 4'd0,
   parameter int         TIMEOUT  = 1024
) (
   input  logic          fclk,
   input  logic          rst,
   input  logic          req_av,
   input  logic          req_we,
   input  logic [31:0]   req_addr,
   input  logic [127:0]  req_dat,
   output logic          req_re,
   output logic          rsp_av,
   output logic [31:0]   rsp_addr,
   output logic [127:0]  rsp_dat,
   output logic          err,
   output logic [1:0]    err_code,
   output logic          busy,
   output logic          tx_av,
   input  logic          tx_re,
   output noc_packet     tx_dat,
   input  logic          rx_av,
   output logic          rx_re,
   input  noc_packet     rx_dat
);
   typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;

   localparam logic [7:0] WR_LEN = 8'(($bits(noc_packet_header) + $bits(mem_wr_rq)) / 8);
   localparam logic [7:0] RD_LEN = 8'(($bits(noc_packet_header) + $bits(mem_rd_rq)) / 8);

   state_t         state_q;
   logic           we_q;
   logic [31:0]    addr_q;
   logic [127:0]   dat_q;
   logic [15:0]    timer_q;
   logic           req_re_q, rsp_av_q, err_q, busy_q, tx_av_q, rx_re_q;
   logic [1:0]     err_code_q;
   logic [31:0]    rsp_addr_q;
   logic [127:0]   rsp_dat_q;
   noc_packet      tx_dat_q;

   noc_packet      wr_pkt_d, rd_pkt_d;
   mem_wr_rq       wr_pl;
   mem_rd_rq       rd_pl;
   mem_rd_rp       rx_rp;
   logic           pop, is_reply, addr_match, timeout_hit;
   logic           unused_rx_hdr;

   assign unused_rx_hdr = ^rx_dat.hdr;

   always_comb begin
      wr_pl       = '{dat: dat_q, addr: addr_q, pt: memory_write_request};
      rd_pl       = '{addr: addr_q, pt: memory_read_request};
      wr_pkt_d.hdr = '{len: WR_LEN, src_addr: SRC_ADDR, src_port: SRC_PORT,
                       dst_addr: DST_ADDR, dst_port: DST_PORT};
      wr_pkt_d.dat = wr_pl;
      rd_pkt_d.hdr = '{len: RD_LEN, src_addr: SRC_ADDR, src_port: SRC_PORT,
                       dst_addr: DST_ADDR, dst_port: DST_PORT};
      rd_pkt_d.dat = NOC_PAYLOAD_W'(rd_pl);
      rx_rp       = rx_dat.dat;
      // Skip a cycle after each pop so the NIU has time to drop rx_av.
      pop         = rx_av && !rx_re_q;
      is_reply    = (rx_dat.dat[7:0] == memory_read_reply);
      addr_match  = (rx_rp.addr == addr_q);
      timeout_hit = (timer_q == 16'(TIMEOUT - 1));
   end

   always_ff @(posedge fclk) begin
      if (rst) begin
         state_q    <= IDLE;
         we_q       <= 1'b0;
         addr_q     <= '0;
         dat_q      <= '0;
         timer_q    <= '0;
         req_re_q   <= 1'b0;
         rsp_av_q   <= 1'b0;
         rsp_addr_q <= '0;
         rsp_dat_q  <= '0;
         err_q      <= 1'b0;
         err_code_q <= 2'd0;
         busy_q     <= 1'b0;
         tx_av_q    <= 1'b0;
         tx_dat_q   <= '0;
         rx_re_q    <= 1'b0;
      end else begin
         req_re_q   <= 1'b0;
         rsp_av_q   <= 1'b0;
         err_q      <= 1'b0;
         err_code_q <= 2'd0;
         tx_av_q    <= 1'b0;
         rx_re_q    <= 1'b0;
         case (state_q)
            IDLE: begin
               if (req_av) begin
                  we_q     <= req_we;
                  addr_q   <= req_addr;
                  dat_q    <= req_dat;
                  req_re_q <= 1'b1;
                  busy_q   <= 1'b1;
                  state_q  <= SEND;
               end
               if (pop) begin
                  rx_re_q    <= 1'b1;
                  err_q      <= 1'b1;
                  err_code_q <= 2'd3;
               end
            end
            SEND: begin
               if (tx_re) begin
                  tx_av_q  <= 1'b1;
                  tx_dat_q <= we_q ? wr_pkt_d : rd_pkt_d;
                  timer_q  <= '0;
                  if (we_q) begin
                     busy_q  <= 1'b0;
                     state_q <= IDLE;
                  end else begin
                     state_q <= WAIT;
                  end
               end
            end
            WAIT: begin
               timer_q <= timer_q + 16'd1;
               if (pop) rx_re_q <= 1'b1;
               // A matching reply beats a timeout landing on the same cycle.
               if (pop && is_reply && addr_match) begin
                  rsp_av_q   <= 1'b1;
                  rsp_addr_q <= rx_rp.addr;
                  rsp_dat_q  <= rx_rp.dat;
                  busy_q     <= 1'b0;
                  state_q    <= IDLE;
               end else if (timeout_hit) begin
                  err_q      <= 1'b1;
                  err_code_q <= 2'd1;
                  busy_q     <= 1'b0;
                  state_q    <= IDLE;
               end else if (pop) begin
                  err_q      <= 1'b1;
                  err_code_q <= is_reply ? 2'd2 : 2'd3;
               end
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign req_re   = req_re_q;
   assign rsp_av   = rsp_av_q;
   assign rsp_addr = rsp_addr_q;
   assign rsp_dat  = rsp_dat_q;
   assign err      = err_q;
   assign err_code = err_code_q;
   assign busy     = busy_q;
   assign tx_av    = tx_av_q;
   assign tx_dat   = tx_dat_q;
   assign rx_re    = rx_re_q;
endmodule

// File: tb/tb_mem_request_agent.sv
// tb/tb_mem_request_agent.sv - directed bench for mem_request_agent (TIMEOUT=8 main instance, TIMEOUT=4 race instance).
module tb_mem_request_agent;
   import mem_request_agent_pkg::*;

   logic          fclk = 1'b0;
   logic          rst;
   logic          req_av, req_av2, req_we;
   logic [31:0]   req_addr;
   logic [127:0]  req_dat;
   logic          tx_re, rx_av, rx_av2;
   noc_packet     rx_dat;

   logic          req_re, rsp_av, err, busy, tx_av, rx_re;
   logic [31:0]   rsp_addr;
   logic [127:0]  rsp_dat;
   logic [1:0]    err_code;
   noc_packet     tx_dat;

   logic          req_re2, rsp_av2, err2, busy2, tx_av2, rx_re2;
   logic [31:0]   rsp_addr2;
   logic [127:0]  rsp_dat2;
   logic [1:0]    err_code2;
   noc_packet     tx_dat2;

   int checks = 0;
   int errors = 0;
   int n_tx, n_rx, n_err;
   mem_wr_rq wr_p;
   mem_rd_rq rd_p;

   always #5 fclk = ~fclk;

   mem_request_agent #(.SRC_ADDR(8'h11), .SRC_PORT(4'h3), .DST_ADDR(8'h22),
                       .DST_PORT(4'h5), .TIMEOUT(8)) u_dut (
      .fclk(fclk), .rst(rst), .req_av(req_av), .req_we(req_we), .req_addr(req_addr),
      .req_dat(req_dat), .req_re(req_re), .rsp_av(rsp_av), .rsp_addr(rsp_addr),
      .rsp_dat(rsp_dat), .err(err), .err_code(err_code), .busy(busy), .tx_av(tx_av),
      .tx_re(tx_re), .tx_dat(tx_dat), .rx_av(rx_av), .rx_re(rx_re), .rx_dat(rx_dat));

   mem_request_agent #(.SRC_ADDR(8'h11), .SRC_PORT(4'h3), .DST_ADDR(8'h22),
                       .DST_PORT(4'h5), .TIMEOUT(4)) u_dut4 (
      .fclk(fclk), .rst(rst), .req_av(req_av2), .req_we(req_we), .req_addr(req_addr),
      .req_dat(req_dat), .req_re(req_re2), .rsp_av(rsp_av2), .rsp_addr(rsp_addr2),
      .rsp_dat(rsp_dat2), .err(err2), .err_code(err_code2), .busy(busy2), .tx_av(tx_av2),
      .tx_re(tx_re), .tx_dat(tx_dat2), .rx_av(rx_av2), .rx_re(rx_re2), .rx_dat(rx_dat));

   task automatic step();
      @(posedge fclk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic noc_packet mk_reply(input logic [31:0] a, input logic [127:0] d);
      noc_packet p;
      p.hdr = 32'h2B220511;
      p.dat = {d, a, 8'h03};
      return p;
   endfunction

   initial begin
      rst = 1'b1; req_av = 0; req_av2 = 0; req_we = 0; req_addr = '0; req_dat = '0;
      tx_re = 0; rx_av = 0; rx_av2 = 0; rx_dat = '0;
      step(); step();
      chk("rst_req_re", req_re, 0);
      chk("rst_tx_av", tx_av, 0);
      chk("rst_busy", busy, 0);
      chk("rst_tx_dat", tx_dat, 0);
      chk("rst_err", err, 0);
      chk("rst_rsp_av", rsp_av, 0);
      chk("rst_rx_re", rx_re, 0);
      rst = 1'b0;

      // Write, tx_re already high.
      req_av = 1; req_we = 1; req_addr = 32'h1000; req_dat = {16{8'hA5}}; tx_re = 1;
      step();
      chk("wr_req_re", req_re, 1);
      chk("wr_busy", busy, 1);
      req_av = 0;
      step();
      chk("wr_tx_av", tx_av, 1);
      wr_p = tx_dat.dat;
      chk("wr_pt", wr_p.pt, 8'h01);
      chk("wr_addr", wr_p.addr, 32'h1000);
      chk("wr_dat", wr_p.dat, {16{8'hA5}});
      chk("wr_hdr", tx_dat.hdr, 32'h19113225);
      step();
      chk("wr_busy_low", busy, 0);
      chk("wr_tx_av_low", tx_av, 0);

      // Read with tx_re held low, reply 3 cycles after tx_av.
      tx_re = 0; req_av = 1; req_we = 0; req_addr = 32'h2000;
      step();
      chk("rd_req_re", req_re, 1);
      req_av = 0; n_tx = 0;
      repeat (5) begin step(); n_tx += int'(tx_av); end
      chk("rd_hold_no_tx", n_tx, 0);
      tx_re = 1;
      step();
      chk("rd_tx_av", tx_av, 1);
      n_tx += int'(tx_av);
      rd_p = tx_dat.dat[39:0];
      chk("rd_pt", rd_p.pt, 8'h02);
      chk("rd_addr", rd_p.addr, 32'h2000);
      chk("rd_hdr", tx_dat.hdr, 32'h09113225);
      step(); n_tx += int'(tx_av);
      step(); n_tx += int'(tx_av);
      rx_dat = mk_reply(32'h2000, 128'h0123456789ABCDEF0123456789ABCDEF); rx_av = 1;
      step(); n_tx += int'(tx_av);
      chk("rd_rx_re", rx_re, 1);
      chk("rd_rsp_av", rsp_av, 1);
      chk("rd_rsp_addr", rsp_addr, 32'h2000);
      chk("rd_rsp_dat", rsp_dat, 128'h0123456789ABCDEF0123456789ABCDEF);
      chk("rd_no_err", err, 0);
      rx_av = 0;
      step();
      chk("rd_tx_once", n_tx, 1);
      chk("rd_rsp_pulse", rsp_av, 0);
      chk("rd_busy_low", busy, 0);

      // Mismatched reply then matching reply.
      req_av = 1; req_addr = 32'h3000;
      step(); req_av = 0;
      step();
      rx_dat = mk_reply(32'h3040, {4{32'hDEADBEEF}}); rx_av = 1; n_rx = 0;
      step(); n_rx += int'(rx_re);
      chk("mm_err", err, 1);
      chk("mm_code", err_code, 2);
      chk("mm_no_rsp", rsp_av, 0);
      rx_dat = mk_reply(32'h3000, {4{32'hCAFEF00D}});
      step(); n_rx += int'(rx_re);
      chk("mm_gap", rx_re, 0);
      step(); n_rx += int'(rx_re);
      chk("mm_rsp_av", rsp_av, 1);
      chk("mm_rsp_addr", rsp_addr, 32'h3000);
      chk("mm_rsp_dat", rsp_dat, {4{32'hCAFEF00D}});
      chk("mm_no_err2", err, 0);
      rx_av = 0;
      step(); n_rx += int'(rx_re);
      chk("mm_two_pops", n_rx, 2);

      // Timeout with TIMEOUT=8, then a late reply.
      req_av = 1; req_addr = 32'h4000;
      step(); req_av = 0;
      step();
      n_err = 0;
      repeat (7) begin step(); n_err += int'(err); end
      chk("to_no_early_err", n_err, 0);
      chk("to_busy_wait", busy, 1);
      step();
      chk("to_err", err, 1);
      chk("to_code", err_code, 1);
      chk("to_busy_low", busy, 0);
      rx_dat = mk_reply(32'h4000, '0); rx_av = 1;
      step();
      chk("late_rx_re", rx_re, 1);
      chk("late_err", err, 1);
      chk("late_code", err_code, 3);
      chk("late_no_rsp", rsp_av, 0);
      rx_av = 0;
      step();

      // Reset while waiting, with a reply offered on the reset edge.
      req_av = 1; req_addr = 32'h5000;
      step(); req_av = 0;
      step(); step();
      rst = 1; rx_dat = mk_reply(32'h5000, '1); rx_av = 1;
      step();
      chk("mr_req_re", req_re, 0);
      chk("mr_tx_av", tx_av, 0);
      chk("mr_rx_re", rx_re, 0);
      chk("mr_rsp_av", rsp_av, 0);
      chk("mr_err", err, 0);
      chk("mr_err_code", err_code, 0);
      chk("mr_busy", busy, 0);
      chk("mr_tx_dat", tx_dat, 0);
      chk("mr_rsp_addr", rsp_addr, 0);
      rst = 0; rx_av = 0;
      req_av = 1; req_addr = 32'h6000;
      step();
      chk("pr_req_re", req_re, 1);
      req_av = 0;
      step();
      chk("pr_tx_av", tx_av, 1);
      rx_dat = mk_reply(32'h6000, {8{16'h6666}}); rx_av = 1;
      step();
      chk("pr_rsp_av", rsp_av, 1);
      chk("pr_rsp_dat", rsp_dat, {8{16'h6666}});
      rx_av = 0;
      step();

      // Reply lands on the timeout cycle (TIMEOUT=4 instance).
      req_av2 = 1; req_addr = 32'h7000; req_we = 0;
      step();
      chk("race_req_re", req_re2, 1);
      req_av2 = 0;
      step();
      chk("race_tx_av", tx_av2, 1);
      repeat (3) step();
      rx_dat = mk_reply(32'h7000, {4{32'h77777777}}); rx_av2 = 1;
      step();
      chk("race_rsp_av", rsp_av2, 1);
      chk("race_no_err", err2, 0);
      chk("race_rx_re", rx_re2, 1);
      rx_av2 = 0;
      step();
      chk("race_no_err_after", err2, 0);
      chk("race_busy_low", busy2, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
